// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump sequencer: default geometry
// and the FSM state encoding.
package regfile_dump_reader_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 5;
   localparam int NUM_REGS_DEF = 32;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      CAP  = 3'd2,
      HOLD = 3'd3,
      FIN  = 3'd4
   } state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Reads a run of consecutive registers through the regfile's 1-cycle debug
// read port and presents each word with its index on a valid/ready stream.
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_idx,
   input  logic [ADDR_W:0]   count,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              reg_rd_en,
   output logic [ADDR_W-1:0] reg_addr,
   input  logic [DATA_W-1:0] reg_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_idx,
   input  logic              out_ready
);

   localparam logic [ADDR_W:0]   MAX_CNT  = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W:0]   count_clamped;

   assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;

   assign busy      = (state != IDLE);
   assign done      = (state == FIN);
   assign reg_rd_en = (state == REQ);

   // abort overrides every transition, including a same-cycle HOLD handshake
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_next = (count == '0) ? FIN : REQ;
            end
         end
         REQ:  state_next = CAP;
         CAP:  state_next = HOLD;
         HOLD: begin
            if (out_ready) begin
               state_next = (remaining != '0) ? REQ : FIN;
            end
         end
         FIN:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort && state != IDLE) begin
         state_next = IDLE;
      end
   end

   // reg_addr is only reloaded on entry to REQ so it stays put through CAP/HOLD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         remaining <= '0;
         reg_addr  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (state_next == REQ) begin
                  idx       <= start_idx;
                  remaining <= count_clamped;
                  reg_addr  <= start_idx;
               end
            end
            CAP: begin
               if (state_next == HOLD) begin
                  out_data  <= reg_data;
                  out_idx   <= idx;
                  out_valid <= 1'b1;
                  idx       <= (idx == LAST_IDX) ? '0 : idx + ADDR_W'(1);
                  remaining <= remaining - (ADDR_W+1)'(1);
               end
            end
            HOLD: begin
               if (state_next != HOLD) begin
                  out_valid <= 1'b0;
                  if (state_next == REQ) begin
                     reg_addr <= idx;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file
// preloaded as r0=0, rk=0xA5A50000+k.
module tb_regfile_dump_reader;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] start_idx;
   logic [ADDR_W:0]   count;
   logic              abort;
   logic              busy;
   logic              done;
   logic              reg_rd_en;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_data = '0;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_idx;
   logic              out_ready;

   int errors = 0;
   int checks = 0;
   int rdCount = 0;

   logic [ADDR_W-1:0] gotIdx[$];
   logic [DATA_W-1:0] gotData[$];
   int firstValidAt;
   int doneAt;
   int doneCount;
   int rdPulses;

   always #5 clk = ~clk;

   regfile_dump_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .start_idx (start_idx),
      .count     (count),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .reg_rd_en (reg_rd_en),
      .reg_addr  (reg_addr),
      .reg_data  (reg_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_ready (out_ready)
   );

   // Register file read port: registered, r0 hardwired to zero
   always @(posedge clk) begin
      if (reg_rd_en) begin
         reg_data <= (reg_addr == '0) ? 32'h0 : (32'hA5A50000 | {27'b0, reg_addr});
         rdCount  <= rdCount + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Runs one dump with out_ready as currently set, observing a fixed window.
   // injectAt>0 pulses a second start (idx 20, count 1) at that cycle.
   task automatic applyStimulus(input logic [ADDR_W-1:0] sidx, input logic [ADDR_W:0] cnt,
                                input int window, input int injectAt);
      int rdBase;
      gotIdx.delete();
      gotData.delete();
      firstValidAt = -1;
      doneAt       = -1;
      doneCount    = 0;
      @(negedge clk);
      rdBase    = rdCount;
      start_idx = sidx;
      count     = cnt;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= window; cyc++) begin
         if (out_valid && firstValidAt < 0) firstValidAt = cyc;
         if (out_valid && out_ready) begin
            gotIdx.push_back(out_idx);
            gotData.push_back(out_data);
         end
         if (done) begin
            doneCount++;
            if (doneAt < 0) doneAt = cyc;
         end
         if (cyc == injectAt) begin
            start     = 1'b1;
            start_idx = 5'd20;
            count     = 6'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start    = 1'b0;
      rdPulses = rdCount - rdBase;
   endtask

   initial begin
      int rdBase;
      int words;
      int dc;
      bit aborted;
      logic [ADDR_W-1:0] secIdx;
      logic [DATA_W-1:0] secData;
      logic [ADDR_W-1:0] expIdxA[4];
      logic [DATA_W-1:0] expDataA[4];
      logic [ADDR_W-1:0] expIdxB[4];
      logic [DATA_W-1:0] expDataB[4];

      expIdxA  = '{5'd3, 5'd4, 5'd5, 5'd6};
      expDataA = '{32'hA5A50003, 32'hA5A50004, 32'hA5A50005, 32'hA5A50006};
      expIdxB  = '{5'd30, 5'd31, 5'd0, 5'd1};
      expDataB = '{32'hA5A5001E, 32'hA5A5001F, 32'h0, 32'hA5A50001};

      rst = 1'b1; start = 1'b0; start_idx = '0; count = '0; abort = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_rd_en", 32'(reg_rd_en), 32'd0);
      checkOutput("rst_addr", 32'(reg_addr), 32'd0);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_data", out_data, 32'd0);
      checkOutput("rst_idx", 32'(out_idx), 32'd0);
      rst = 1'b0;

      $display("[TB] basic dump idx 3 count 4");
      applyStimulus(5'd3, 6'd4, 18, -1);
      checkOutput("basic_words", 32'(gotIdx.size()), 32'd4);
      for (int i = 0; i < 4 && i < gotIdx.size(); i++) begin
         checkOutput($sformatf("basic_idx%0d", i), 32'(gotIdx[i]), 32'(expIdxA[i]));
         checkOutput($sformatf("basic_data%0d", i), gotData[i], expDataA[i]);
      end
      checkOutput("basic_latency", 32'(firstValidAt), 32'd3);
      checkOutput("basic_done_cnt", 32'(doneCount), 32'd1);
      checkOutput("basic_done_at", 32'(doneAt), 32'd13);
      checkOutput("basic_rd", 32'(rdPulses), 32'd4);

      $display("[TB] wrap dump idx 30 count 4");
      applyStimulus(5'd30, 6'd4, 18, -1);
      checkOutput("wrap_words", 32'(gotIdx.size()), 32'd4);
      for (int i = 0; i < 4 && i < gotIdx.size(); i++) begin
         checkOutput($sformatf("wrap_idx%0d", i), 32'(gotIdx[i]), 32'(expIdxB[i]));
         checkOutput($sformatf("wrap_data%0d", i), gotData[i], expDataB[i]);
      end

      $display("[TB] backpressure dump idx 8 count 2");
      out_ready = 1'b0;
      @(negedge clk);
      rdBase = rdCount;
      start_idx = 5'd8; count = 6'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("stall_data%0d", i), out_data, 32'hA5A50008);
         checkOutput($sformatf("stall_idx%0d", i), 32'(out_idx), 32'd8);
         checkOutput($sformatf("stall_rd%0d", i), 32'(reg_rd_en), 32'd0);
         checkOutput($sformatf("stall_addr%0d", i), 32'(reg_addr), 32'd8);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      secIdx = '0; secData = '0; dc = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) begin
            secIdx  = out_idx;
            secData = out_data;
         end
         if (done) dc++;
         @(negedge clk);
      end
      checkOutput("stall_sec_idx", 32'(secIdx), 32'd9);
      checkOutput("stall_sec_data", secData, 32'hA5A50009);
      checkOutput("stall_rd_total", 32'(rdCount - rdBase), 32'd2);
      checkOutput("stall_done_cnt", 32'(dc), 32'd1);

      $display("[TB] empty dump count 0");
      applyStimulus(5'd7, 6'd0, 6, -1);
      checkOutput("zero_words", 32'(gotIdx.size()), 32'd0);
      checkOutput("zero_rd", 32'(rdPulses), 32'd0);
      checkOutput("zero_done_at", 32'(doneAt), 32'd1);
      checkOutput("zero_done_cnt", 32'(doneCount), 32'd1);

      $display("[TB] oversize dump idx 5 count 40");
      applyStimulus(5'd5, 6'd40, 102, -1);
      checkOutput("clamp_words", 32'(gotIdx.size()), 32'd32);
      if (gotIdx.size() == 32) begin
         checkOutput("clamp_first_idx", 32'(gotIdx[0]), 32'd5);
         checkOutput("clamp_r0_idx", 32'(gotIdx[27]), 32'd0);
         checkOutput("clamp_r0_data", gotData[27], 32'h0);
         checkOutput("clamp_last_idx", 32'(gotIdx[31]), 32'd4);
         checkOutput("clamp_last_data", gotData[31], 32'hA5A50004);
      end
      checkOutput("clamp_rd", 32'(rdPulses), 32'd32);
      checkOutput("clamp_done_at", 32'(doneAt), 32'd97);

      $display("[TB] abort on second of five words");
      @(negedge clk);
      rdBase = rdCount;
      start_idx = 5'd10; count = 6'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      words = 0; aborted = 1'b0;
      for (int cyc = 1; cyc <= 20 && !aborted; cyc++) begin
         if (out_valid) begin
            words++;
            if (words == 2) begin
               abort   = 1'b1;
               aborted = 1'b1;
            end
         end
         @(negedge clk);
      end
      abort = 1'b0;
      checkOutput("abort_reached", 32'(aborted), 32'd1);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_valid", 32'(out_valid), 32'd0);
      dc = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) dc++;
         @(negedge clk);
      end
      checkOutput("abort_no_done", 32'(dc), 32'd0);
      checkOutput("abort_rd", 32'(rdCount - rdBase), 32'd2);

      applyStimulus(5'd17, 6'd1, 6, -1);
      checkOutput("post_abort_words", 32'(gotIdx.size()), 32'd1);
      if (gotIdx.size() == 1) begin
         checkOutput("post_abort_idx", 32'(gotIdx[0]), 32'd17);
         checkOutput("post_abort_data", gotData[0], 32'hA5A50011);
      end
      checkOutput("post_abort_done_at", 32'(doneAt), 32'd4);

      $display("[TB] start while busy");
      applyStimulus(5'd12, 6'd2, 12, 2);
      checkOutput("busy_start_words", 32'(gotIdx.size()), 32'd2);
      if (gotIdx.size() == 2) checkOutput("busy_start_idx1", 32'(gotIdx[1]), 32'd13);
      checkOutput("busy_start_done_cnt", 32'(doneCount), 32'd1);
      checkOutput("busy_start_rd", 32'(rdPulses), 32'd2);
      checkOutput("busy_start_idle", 32'(busy), 32'd0);

      $display("[TB] reset during CAP");
      @(negedge clk);
      start_idx = 5'd2; count = 6'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_done", 32'(done), 32'd0);
      checkOutput("midrst_rd_en", 32'(reg_rd_en), 32'd0);
      checkOutput("midrst_addr", 32'(reg_addr), 32'd0);
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_data", out_data, 32'd0);
      checkOutput("midrst_idx", 32'(out_idx), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(5'd2, 6'd3, 14, -1);
      checkOutput("restart_words", 32'(gotIdx.size()), 32'd3);
      if (gotIdx.size() == 3) begin
         checkOutput("restart_idx0", 32'(gotIdx[0]), 32'd2);
         checkOutput("restart_data2", gotData[2], 32'hA5A50004);
      end
      checkOutput("restart_done_at", 32'(doneAt), 32'd10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
